// File: rtl/if_fetch_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_fetch_queue : sequential instruction fetch with a DEPTH-entry prefetch
//                  queue, valid/stall handshake to decode and jump flush.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       jmp,
  input  logic [ADDR_W-1:0]          new_inst_addr,
  input  logic                       if_stall,
  output logic                       ce,
  output logic [ADDR_W-1:0]          req_addr,
  input  logic                       mem_ready,
  input  logic [INST_W-1:0]          mem_rdata,
  output logic                       inst_valid,
  output logic [INST_W-1:0]          inst,
  output logic [ADDR_W-1:0]          inst_addr,
  output logic [$clog2(DEPTH):0]     queue_cnt
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] tag;
  logic              run;
  logic              inflight;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              credit;
  logic              accept;
  logic              push;
  logic              pop;

  // The in-flight slot is reserved up front so a response can never land on a full queue.
  assign credit     = (cnt + CNT_W'(inflight)) < DEPTH_C;
  assign ce         = run && !jmp && credit;
  assign req_addr   = pc;
  assign accept     = ce && mem_ready;
  assign push       = inflight && !jmp;
  assign inst_valid = (cnt != '0);
  assign pop        = inst_valid && !if_stall && !jmp;
  assign inst       = inst_mem[rd_ptr];
  assign inst_addr  = addr_mem[rd_ptr];
  assign queue_cnt  = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      tag      <= '0;
      run      <= 1'b0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (jmp) begin
        pc       <= new_inst_addr;
        inflight <= 1'b0;
        cnt      <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        inflight <= accept;
        if (accept) begin
          pc  <= pc + PC_STEP;
          tag <= pc;
        end
        if (push) begin
          inst_mem[wr_ptr] <= mem_rdata;
          addr_mem[wr_ptr] <= tag;
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          cnt <= cnt + 1'b1;
        end else if (!push && pop) begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// Directed vector bench for if_fetch_queue: a 32-bit/depth-4 instance and a
// 16-bit/depth-8 instance share stimulus; each row checks one of them.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        jmp;
  logic [31:0] new_addr;
  logic        if_stall;
  logic        mem_ready;

  logic        ce0, v0;
  logic [31:0] req0, ia0, inst0, rdata0;
  logic [2:0]  cnt0;

  logic        ce1, v1;
  logic [15:0] req1, ia1;
  logic [31:0] inst1, rdata1;
  logic [3:0]  cnt1;

  int vectors;
  int miscompares;
  bit acc0, acc1;

  if_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .jmp(jmp), .new_inst_addr(new_addr),
    .if_stall(if_stall), .ce(ce0), .req_addr(req0), .mem_ready(mem_ready),
    .mem_rdata(rdata0), .inst_valid(v0), .inst(inst0), .inst_addr(ia0),
    .queue_cnt(cnt0)
  );

  if_fetch_queue #(.ADDR_W(16), .INST_W(32), .DEPTH(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .jmp(jmp), .new_inst_addr(new_addr[15:0]),
    .if_stall(if_stall), .ce(ce1), .req_addr(req1), .mem_ready(mem_ready),
    .mem_rdata(rdata1), .inst_valid(v1), .inst(inst1), .inst_addr(ia1),
    .queue_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  // One-cycle-latency instruction memory per instance
  always @(posedge clk) begin
    if (ce0 && mem_ready) rdata0 <= memf(req0);
    if (ce1 && mem_ready) rdata1 <= memf({16'h0, req1});
  end

  typedef struct {
    bit          sel;
    bit          rs;
    bit          rst;
    bit          jmp;
    logic [31:0] na;
    bit          st;
    bit          rdy;
    bit          e_ce;
    logic [31:0] e_req;
    bit          e_v;
    logic [31:0] e_ia;
    logic [7:0]  e_cnt;
    bit          z;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit sel, bit rs, bit rst, bit j, logic [31:0] na, bit st,
                              bit rdy, bit ece, logic [31:0] ereq, bit ev,
                              logic [31:0] eia, int ecnt, bit z);
    vec_t t;
    t.sel = sel; t.rs = rs; t.rst = rst; t.jmp = j; t.na = na; t.st = st; t.rdy = rdy;
    t.e_ce = ece; t.e_req = ereq; t.e_v = ev; t.e_ia = eia; t.e_cnt = 8'(ecnt); t.z = z;
    return t;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  // Credit must rule out a response arriving at a full queue.
  task automatic inv_check(int idx);
    vectors++;
    if (rst_n && !jmp && ((acc0 && cnt0 == 3'd4) || (acc1 && cnt1 == 4'd8))) begin
      miscompares++;
      $display("FAIL push_full row %0d: got cnt0=%0d cnt1=%0d, expected room for response",
               idx, cnt0, cnt1);
    end
  endtask

  task automatic do_reset(int idx);
    rst_n = 1'b0; jmp = 1'b0; new_addr = '0; if_stall = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    chk("rst_ce0", idx, {31'h0, ce0}, 32'h0);
    chk("rst_v0", idx, {31'h0, v0}, 32'h0);
    chk("rst_cnt0", idx, {29'h0, cnt0}, 32'h0);
    chk("rst_req0", idx, req0, 32'h0);
    chk("rst_ia0", idx, ia0, 32'h0);
    chk("rst_inst0", idx, inst0, 32'h0);
    chk("rst_ce1", idx, {31'h0, ce1}, 32'h0);
    chk("rst_v1", idx, {31'h0, v1}, 32'h0);
    chk("rst_cnt1", idx, {28'h0, cnt1}, 32'h0);
    chk("rst_ia1", idx, {16'h0, ia1}, 32'h0);
    acc0 = 1'b0;
    acc1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(vec_t t, int idx);
    logic        a_ce, a_v;
    logic [31:0] a_req, a_ia, a_inst;
    logic [7:0]  a_cnt;
    if (t.rs) do_reset(idx);
    rst_n = t.rst; jmp = t.jmp; new_addr = t.na; if_stall = t.st; mem_ready = t.rdy;
    @(negedge clk);
    if (t.sel) begin
      a_ce = ce1; a_v = v1; a_req = {16'h0, req1}; a_ia = {16'h0, ia1};
      a_inst = inst1; a_cnt = {4'h0, cnt1};
    end else begin
      a_ce = ce0; a_v = v0; a_req = req0; a_ia = ia0; a_inst = inst0; a_cnt = {5'h0, cnt0};
    end
    vectors++;
    chk("ce", idx, {31'h0, a_ce}, {31'h0, t.e_ce});
    chk("req_addr", idx, a_req, t.e_req);
    chk("inst_valid", idx, {31'h0, a_v}, {31'h0, t.e_v});
    chk("queue_cnt", idx, {24'h0, a_cnt}, {24'h0, t.e_cnt});
    if (t.e_v) begin
      chk("inst_addr", idx, a_ia, t.e_ia);
      chk("inst", idx, a_inst, memf(t.e_ia));
    end else if (t.z) begin
      chk("inst_addr_zero", idx, a_ia, 32'h0);
      chk("inst_zero", idx, a_inst, 32'h0);
    end
    inv_check(idx);
    acc0 = rst_n && ce0 && mem_ready;
    acc1 = rst_n && ce1 && mem_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; acc0 = 1'b0; acc1 = 1'b0;
    rst_n = 1'b0; jmp = 1'b0; new_addr = '0; if_stall = 1'b0; mem_ready = 1'b1;

    // Free-running fetch: one request per cycle from cycle 2, queue never above 1
    vecs.push_back(mk(0,1,1,0,0,0,1, 0,32'h0,  0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h0,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h4,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h8,  1,32'h0,1,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'hC,  1,32'h4,1,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h10, 1,32'h8,1,0));
    // Stall from reset: four accepts then credit stops fetch; one pop re-opens it
    vecs.push_back(mk(0,1,1,0,0,1,1, 0,32'h0,  0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h0,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h4,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h8,  1,32'h0,1,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'hC,  1,32'h0,2,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 0,32'h10, 1,32'h0,3,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 0,32'h10, 1,32'h0,4,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 0,32'h10, 1,32'h0,4,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 0,32'h10, 1,32'h0,4,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h10, 1,32'h4,3,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 0,32'h14, 1,32'h4,3,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 0,32'h14, 1,32'h4,4,0));
    // Jump under stall with 3 queued + 1 in flight: flush, stale response dropped
    vecs.push_back(mk(0,1,1,0,0,1,1, 0,32'h0,  0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h0,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h4,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h8,  1,32'h0,1,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'hC,  1,32'h0,2,0));
    vecs.push_back(mk(0,0,1,1,32'h100,1,1, 0,32'h10, 1,32'h0,3,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h100, 0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h104, 0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h108, 1,32'h100,1,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h10C, 1,32'h104,1,0));
    // mem_ready 1,0,0,1: request held, no gap or duplicate in the stream
    vecs.push_back(mk(0,1,1,0,0,0,1, 0,32'h0,  0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h0,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 1,32'h4,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0, 1,32'h4,  1,32'h0,1,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h4,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h8,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'hC,  1,32'h4,1,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h10, 1,32'h8,1,0));
    // Reset with 2 queued + 1 in flight: everything cleared, restart at 0
    vecs.push_back(mk(0,1,1,0,0,1,1, 0,32'h0,  0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h0,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h4,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,1,1, 1,32'h8,  1,32'h0,1,0));
    vecs.push_back(mk(0,0,0,0,0,1,1, 1,32'hC,  1,32'h0,2,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 0,32'h0,  0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h0,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h4,  0,32'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,1, 1,32'h8,  1,32'h0,1,0));
    // 16-bit / depth-8: pc wrap at 0xFFFC, fill to 8, pointer wrap under push+pop
    vecs.push_back(mk(1,1,1,0,0,0,1, 0,32'h0,  0,32'h0,0,1));
    vecs.push_back(mk(1,0,1,1,32'hFFFC,0,1, 0,32'h0, 0,32'h0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'hFFFC, 0,32'h0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h0,  0,32'h0,0,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h4,  1,32'hFFFC,1,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h8,  1,32'h0,1,0));
    vecs.push_back(mk(1,0,1,0,0,1,1, 1,32'hC,  1,32'h4,1,0));
    vecs.push_back(mk(1,0,1,0,0,1,1, 1,32'h10, 1,32'h4,2,0));
    vecs.push_back(mk(1,0,1,0,0,1,1, 1,32'h14, 1,32'h4,3,0));
    vecs.push_back(mk(1,0,1,0,0,1,1, 1,32'h18, 1,32'h4,4,0));
    vecs.push_back(mk(1,0,1,0,0,1,1, 1,32'h1C, 1,32'h4,5,0));
    vecs.push_back(mk(1,0,1,0,0,1,1, 1,32'h20, 1,32'h4,6,0));
    vecs.push_back(mk(1,0,1,0,0,1,1, 0,32'h24, 1,32'h4,7,0));
    vecs.push_back(mk(1,0,1,0,0,1,1, 0,32'h24, 1,32'h4,8,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 0,32'h24, 1,32'h4,8,0));
    vecs.push_back(mk(1,0,1,0,0,1,1, 1,32'h24, 1,32'h8,7,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 0,32'h28, 1,32'h8,7,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h28, 1,32'hC,7,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h2C, 1,32'h10,6,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h30, 1,32'h14,6,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h34, 1,32'h18,6,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h38, 1,32'h1C,6,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h3C, 1,32'h20,6,0));
    vecs.push_back(mk(1,0,1,0,0,0,1, 1,32'h40, 1,32'h24,6,0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
